// File: rtl/nn_pkg.sv
// Shared types and defaults for the activation-output serializer.
// The state encoding is used by the top; the data typedef matches the default width.
package nn_pkg;

    localparam int NN_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    typedef logic [NN_DATA_W-1:0] nn_data_t;

endpackage

// File: rtl/nn_mux_n.sv
// Combinational N_CH:1 channel select from a flat capture bank.
// An index beyond the last channel falls back to the top channel.
module nn_mux_n
    import nn_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int N_CH   = 16
) (
    input  logic [N_CH*DATA_W-1:0]                      data_in,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] idx,
    output logic [DATA_W-1:0]                           data_out
);

    localparam int CNT_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    always_comb begin
        // NOTE: the default assignment before the loop keeps this purely combinational (no latch).
        data_out = data_in[(N_CH-1)*DATA_W +: DATA_W];
        for (int k = 0; k < N_CH; k++) begin
            if (idx == CNT_W'(k)) begin
                data_out = data_in[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/nn_out_serializer.sv
// Captures one layer of N_CH activations in a single handshake and streams them
// one per cycle into the next layer's input FIFO, mirroring to memory on the last layer.
module nn_out_serializer
    import nn_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int N_CH   = 16,
    parameter int ADDR_W = 32
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         load_valid,
    output logic                                         load_ready,
    input  logic [N_CH*DATA_W-1:0]                       load_data,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1):0]    load_count,
    input  logic                                         last_layer,
    input  logic [ADDR_W-1:0]                            mem_base,
    input  logic                                         fifo_full,
    output logic                                         fifo_wr_en,
    output logic [DATA_W-1:0]                            fifo_wr_data,
    output logic                                         mem_we,
    output logic [ADDR_W-1:0]                            mem_addr,
    output logic [DATA_W-1:0]                            mem_wdata,
    output logic                                         busy,
    output logic                                         done
);

    localparam int CNT_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    ser_state_t                state_q, state_d;
    logic [N_CH*DATA_W-1:0]    data_q,  data_d;
    logic [CNT_W:0]            count_q, count_d;
    logic [CNT_W-1:0]          idx_q,   idx_d;
    logic                      last_q,  last_d;
    logic [ADDR_W-1:0]         base_q,  base_d;

    logic [CNT_W:0]            count_clamped;
    logic [DATA_W-1:0]         sel_data;
    logic                      in_shift;
    logic                      write_now;

    nn_mux_n #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH)
    ) u_mux (
        .data_in  (data_q),
        .idx      (idx_q),
        .data_out (sel_data)
    );

    assign count_clamped = (load_count > (CNT_W+1)'(N_CH)) ? (CNT_W+1)'(N_CH) : load_count;
    assign in_shift      = (state_q == SHIFT);
    assign write_now     = in_shift && !fifo_full;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        idx_d   = idx_q;
        last_d  = last_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    data_d  = load_data;
                    count_d = count_clamped;
                    last_d  = last_layer;
                    base_d  = mem_base;
                    idx_d   = '0;
                    state_d = (count_clamped != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                // A stalled cycle holds idx so no channel is dropped or repeated.
                if (write_now) begin
                    if ({1'b0, idx_q} == count_q - 1'b1) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous so an abort takes effect immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            base_q  <= base_d;
        end
    end

    assign load_ready   = (state_q == IDLE);
    assign busy         = (state_q == SHIFT) || (state_q == DONE);
    assign done         = (state_q == DONE);
    assign fifo_wr_en   = write_now;
    assign mem_we       = write_now && last_q;
    assign fifo_wr_data = in_shift ? sel_data : '0;
    assign mem_wdata    = fifo_wr_data;
    assign mem_addr     = in_shift ? (base_q + ADDR_W'(idx_q)) : '0;

endmodule

// File: tb/tb_nn_out_serializer.sv
// Directed scenario bench for nn_out_serializer with hand-derived expected streams.
// Each task drives one scenario and compares the observed outputs inline.
module tb_nn_out_serializer;

    localparam int DATA_W = 8;
    localparam int N_CH   = 16;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic                     clk;
    logic                     reset_n;
    logic                     load_valid;
    logic                     load_ready;
    logic [N_CH*DATA_W-1:0]   load_data;
    logic [CNT_W:0]           load_count;
    logic                     last_layer;
    logic [ADDR_W-1:0]        mem_base;
    logic                     fifo_full;
    logic                     fifo_wr_en;
    logic [DATA_W-1:0]        fifo_wr_data;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     busy;
    logic                     done;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_d [16];
    logic [7:0]  cap_data [64];
    logic [31:0] cap_addr [64];
    logic        cap_mem  [64];
    int          nw;
    int          done_cyc;
    int          ndone;

    nn_out_serializer #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_count   (load_count),
        .last_layer   (last_layer),
        .mem_base     (mem_base),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_pattern(input logic [7:0] base, input logic [7:0] step);
        for (int k = 0; k < 16; k++) exp_d[k] = base + 8'(k) * step;
    endtask

    function automatic logic [N_CH*DATA_W-1:0] pack_pattern();
        logic [N_CH*DATA_W-1:0] v;
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = exp_d[k];
        return v;
    endfunction

    task automatic do_load(input int cnt, input logic last, input logic [31:0] base);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = pack_pattern();
        load_count = 5'(cnt);
        last_layer = last;
        mem_base   = base;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_before_load: got %b want 1", load_ready);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_count = 5'd0;
        last_layer = ~last;
        mem_base   = 32'hDEAD_BEEF;
        load_data  = '1;
    endtask

    // Observes the stream after an accepted load; optionally stalls after stall_at writes.
    task automatic capture(input int stall_at, input int stall_len, input int max_cyc);
        int n = 0;
        int stalled = 0;
        nw = 0;
        done_cyc = -1;
        ndone = 0;
        while (n < max_cyc && !(done_cyc >= 0 && n >= done_cyc + 2)) begin
            n++;
            @(negedge clk);
            fifo_full = (nw == stall_at) && (stalled < stall_len);
            if (fifo_full) stalled++;
            #1;
            if (fifo_full && (fifo_wr_en || mem_we)) begin
                errors++;
                $display("FAIL write_while_full: cycle %0d wr_en=%b mem_we=%b want 0", n, fifo_wr_en, mem_we);
            end
            if (mem_we && !fifo_wr_en) begin
                errors++;
                $display("FAIL split_write: cycle %0d mem_we=1 with fifo_wr_en=0", n);
            end
            if (fifo_wr_en) begin
                checks++;
                if (mem_wdata !== fifo_wr_data || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL wdata_busy: cycle %0d mem_wdata=%h fifo=%h busy=%b", n, mem_wdata, fifo_wr_data, busy);
                end
                if (nw < 64) begin
                    cap_data[nw] = fifo_wr_data;
                    cap_addr[nw] = mem_addr;
                    cap_mem[nw]  = mem_we;
                end
                nw++;
            end
            if (done === 1'b1) begin
                if (done_cyc < 0) done_cyc = n;
                ndone++;
            end
        end
        fifo_full = 1'b0;
    endtask

    task automatic check_stream(input string name, input int exp_nw, input int exp_done,
                                input logic exp_mem, input logic [31:0] base);
        checks++;
        if (nw !== exp_nw) begin
            errors++;
            $display("FAIL %s_count: got %0d writes want %0d", name, nw, exp_nw);
        end
        checks++;
        if (done_cyc !== exp_done || ndone !== 1) begin
            errors++;
            $display("FAIL %s_done: got cycle %0d (pulses %0d) want cycle %0d (1 pulse)", name, done_cyc, ndone, exp_done);
        end
        for (int i = 0; i < exp_nw && i < nw; i++) begin
            checks++;
            if (cap_data[i] !== exp_d[i] || cap_mem[i] !== exp_mem ||
                (exp_mem && cap_addr[i] !== base + 32'(i))) begin
                errors++;
                $display("FAIL %s_ch%0d: data=%h mem=%b addr=%h want data=%h mem=%b addr=%h",
                         name, i, cap_data[i], cap_mem[i], cap_addr[i], exp_d[i], exp_mem, base + 32'(i));
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if (load_ready !== 1'b1 || fifo_wr_en !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || fifo_wr_data !== 8'h00 || mem_addr !== 32'h0 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: ready=%b wr=%b we=%b busy=%b done=%b data=%h addr=%h",
                     load_ready, fifo_wr_en, mem_we, busy, done, fifo_wr_data, mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b want 1/0", load_ready, busy);
        end
    endtask

    task automatic test_full_stream();
        set_pattern(8'h30, 8'h07);
        do_load(16, 1'b0, 32'h0000_1000);
        capture(-1, 0, 40);
        check_stream("stream16", 16, 17, 1'b0, 32'h0);
    endtask

    task automatic test_mem_write();
        set_pattern(8'h11, 8'h11);
        do_load(4, 1'b1, 32'h0000_0040);
        capture(-1, 0, 20);
        check_stream("mem4", 4, 5, 1'b1, 32'h0000_0040);
    endtask

    task automatic test_stall();
        set_pattern(8'hC3, 8'h05);
        do_load(16, 1'b0, 32'h0);
        capture(5, 3, 40);
        check_stream("stall", 16, 20, 1'b0, 32'h0);
    endtask

    task automatic test_count_edges();
        set_pattern(8'h01, 8'h01);
        do_load(0, 1'b1, 32'h0);
        capture(-1, 0, 10);
        check_stream("count0", 0, 1, 1'b1, 32'h0);
        set_pattern(8'h80, 8'h03);
        do_load(20, 1'b0, 32'h0);
        capture(-1, 0, 40);
        check_stream("clamp20", 16, 17, 1'b0, 32'h0);
        set_pattern(8'h5A, 8'h21);
        do_load(4, 1'b1, 32'hFFFF_FFFE);
        capture(-1, 0, 20);
        check_stream("wrap", 4, 5, 1'b1, 32'hFFFF_FFFE);
        checks++;
        if (cap_addr[2] !== 32'h0 || cap_addr[3] !== 32'h1) begin
            errors++;
            $display("FAIL wrap_addr: got %h %h want 00000000 00000001", cap_addr[2], cap_addr[3]);
        end
    endtask

    task automatic test_async_reset();
        set_pattern(8'h40, 8'h09);
        do_load(16, 1'b1, 32'h100);
        repeat (7) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (fifo_wr_en !== 1'b1 || mem_we !== 1'b1 || fifo_wr_data !== exp_d[7]) begin
            errors++;
            $display("FAIL pre_abort: wr=%b we=%b data=%h want 1 1 %h", fifo_wr_en, mem_we, fifo_wr_data, exp_d[7]);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (fifo_wr_en !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: wr=%b we=%b busy=%b done=%b want 0", fifo_wr_en, mem_we, busy, done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_abort: ready=%b done=%b want 1 0", load_ready, done);
        end
        set_pattern(8'h07, 8'h0B);
        do_load(16, 1'b0, 32'h0);
        capture(-1, 0, 40);
        check_stream("restart", 16, 17, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [N_CH*DATA_W-1:0] layer_b;
        int acc_cyc = -1;
        int k = 0;
        set_pattern(8'hE0, 8'h02);
        layer_b = '0;
        for (int i = 0; i < 16; i++) layer_b[i*8 +: 8] = 8'h10 + 8'(i) * 8'h0D;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = pack_pattern();
        load_count = 5'd4;
        last_layer = 1'b0;
        mem_base   = 32'h0;
        @(posedge clk);
        #1;
        load_data  = layer_b;
        load_count = 5'd3;
        last_layer = 1'b1;
        mem_base   = 32'h200;
        for (int n = 1; n <= 12 && acc_cyc < 0; n++) begin
            @(negedge clk);
            #1;
            if (load_ready === 1'b1) acc_cyc = n;
            if (fifo_wr_en === 1'b1) begin
                checks++;
                if (k > 3 || fifo_wr_data !== exp_d[k] || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL layer_a_ch%0d: data=%h we=%b want %h 0", k, fifo_wr_data, mem_we, exp_d[k & 15]);
                end
                k++;
            end
        end
        checks++;
        if (acc_cyc !== 6 || k !== 4) begin
            errors++;
            $display("FAIL held_load_accept: ready at cycle %0d after %0d writes want cycle 6 after 4", acc_cyc, k);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = '0;
        for (int i = 0; i < 16; i++) exp_d[i] = layer_b[i*8 +: 8];
        capture(-1, 0, 20);
        check_stream("layer_b", 3, 4, 1'b1, 32'h200);
    endtask

    initial begin
        load_valid = 1'b0;
        load_data  = '0;
        load_count = '0;
        last_layer = 1'b0;
        mem_base   = '0;
        fifo_full  = 1'b0;
        test_reset();
        test_full_stream();
        test_mem_write();
        test_stall();
        test_count_edges();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
